// File: rtl/sid_i2s_out.sv
// sid_i2s_out: audio output stage for the dual-SID engine.
// A per-channel one-pole low-pass (or bypass) feeds a Philips I2S master
// serializer. BCLK is a divided clock-enable running on the system clock.
module sid_i2s_out #(
   parameter int BCLK_DIV  = 8,   // clk cycles per BCLK half-period, >= 2
   parameter int LPF_SHIFT = 3    // filter coefficient alpha = 2^-LPF_SHIFT, 1..8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [23:0] audio_i_l,
   input  logic [23:0] audio_i_r,
   input  logic        audio_valid,
   input  logic        lpf_en,
   output logic        i2s_bclk,
   output logic        i2s_lrclk,
   output logic        i2s_sdata,
   output logic        frame_strobe
);

   localparam int DIV_W = $clog2(BCLK_DIV);
   localparam int ACC_W = 24 + LPF_SHIFT + 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

   logic [DIV_W-1:0]        div_r;
   logic [5:0]              bit_r;
   logic [5:0]              bit_next_s;
   logic                    fall_s;
   logic                    wrap_s;
   logic signed [ACC_W-1:0] acc_l_r;
   logic signed [ACC_W-1:0] acc_r_r;
   logic [23:0]             y_l_s;
   logic [23:0]             y_r_s;
   logic [23:0]             frame_l_r;
   logic [23:0]             frame_r_r;

   // One filter step. The accumulator is wide enough that the steady state
   // x * 2^F always fits, so modular intermediate sums give exact results.
   function automatic logic signed [ACC_W-1:0] lpf_step(
      input logic signed [ACC_W-1:0] acc,
      input logic [23:0]             x,
      input logic                    en
   );
      logic signed [ACC_W-1:0] x_ext;
      x_ext = {{(LPF_SHIFT + 1){x[23]}}, x};
      if (en) begin
         lpf_step = acc + x_ext - (acc >>> LPF_SHIFT);
      end else begin
         // Bypass keeps the accumulator aligned to the input so that
         // re-enabling the filter produces no step.
         lpf_step = x_ext <<< LPF_SHIFT;
      end
   endfunction

   // Serial bit for a slot: 24 data bits start one slot after each LRCLK
   // edge (Philips framing), everything else is zero padding.
   function automatic logic slot_bit(
      input logic [5:0]  slot,
      input logic [23:0] left,
      input logic [23:0] right
   );
      logic [4:0] idx;
      logic       bit_v;
      idx   = 5'd0;
      bit_v = 1'b0;
      if ((slot >= 6'd1) && (slot <= 6'd24)) begin
         idx   = 5'(6'd24 - slot);
         bit_v = left[idx];
      end else if ((slot >= 6'd33) && (slot <= 6'd56)) begin
         idx   = 5'(6'd56 - slot);
         bit_v = right[idx];
      end else begin
         bit_v = 1'b0;
      end
      return bit_v;
   endfunction

   assign fall_s     = (div_r == DIV_LAST) && i2s_bclk;
   assign bit_next_s = bit_r + 6'd1;
   assign wrap_s     = (bit_next_s == 6'd0);
   assign y_l_s      = acc_l_r[LPF_SHIFT+23:LPF_SHIFT];
   assign y_r_s      = acc_r_r[LPF_SHIFT+23:LPF_SHIFT];

   // Per-channel low-pass accumulators, advanced only on new samples.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_l_r <= '0;
         acc_r_r <= '0;
      end else if (audio_valid) begin
         acc_l_r <= lpf_step(acc_l_r, audio_i_l, lpf_en);
         acc_r_r <= lpf_step(acc_r_r, audio_i_r, lpf_en);
      end else begin
         acc_l_r <= acc_l_r;
         acc_r_r <= acc_r_r;
      end
   end

   // BCLK divider: toggle the bit clock at every terminal count.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_r    <= '0;
         i2s_bclk <= 1'b0;
      end else if (div_r == DIV_LAST) begin
         div_r    <= '0;
         i2s_bclk <= ~i2s_bclk;
      end else begin
         div_r    <= div_r + DIV_W'(1'b1);
         i2s_bclk <= i2s_bclk;
      end
   end

   // Slot counter, word select, serial data and frame latch; all change on
   // BCLK falls so the receiver samples mid-bit on the rising edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         bit_r        <= 6'd63;
         i2s_lrclk    <= 1'b1;
         i2s_sdata    <= 1'b0;
         frame_strobe <= 1'b0;
         frame_l_r    <= 24'd0;
         frame_r_r    <= 24'd0;
      end else begin
         frame_strobe <= 1'b0;
         if (fall_s) begin
            bit_r     <= bit_next_s;
            i2s_lrclk <= bit_next_s[5];
            i2s_sdata <= slot_bit(bit_next_s, frame_l_r, frame_r_r);
            if (wrap_s) begin
               // y is read before any same-cycle filter update lands.
               frame_l_r    <= y_l_s;
               frame_r_r    <= y_r_s;
               frame_strobe <= 1'b1;
            end else begin
               frame_l_r <= frame_l_r;
               frame_r_r <= frame_r_r;
            end
         end else begin
            bit_r <= bit_r;
         end
      end
   end

endmodule

// File: tb/tb_sid_i2s_out.sv
// Self-checking bench for sid_i2s_out (BCLK_DIV=2, LPF_SHIFT=3).
// Expected frames are queued as stimulus is applied; a monitor decodes the
// I2S stream at BCLK rising edges and compares each frame against the queue.
module tb_sid_i2s_out;

   localparam int BCLK_DIV = 2;
   localparam int LPF_F    = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic [23:0] audio_i_l;
   logic [23:0] audio_i_r;
   logic        audio_valid;
   logic        lpf_en;
   logic        i2s_bclk;
   logic        i2s_lrclk;
   logic        i2s_sdata;
   logic        frame_strobe;

   typedef struct {
      logic [23:0] l;
      logic [23:0] r;
   } frame_t;

   frame_t      exp_q[$];
   int          tests_run    = 0;
   int          tests_failed = 0;
   int          pushed       = 0;
   int          compared     = 0;
   bit          mon_busy     = 1'b0;
   logic [23:0] last_l       = 24'd0;
   logic [23:0] last_r       = 24'd0;
   longint      m_acc_l      = 0;
   longint      m_acc_r      = 0;
   int          trk_err      = 0;
   int          wrap_err     = 0;

   sid_i2s_out #(.BCLK_DIV(BCLK_DIV), .LPF_SHIFT(LPF_F)) dut (
      .clk          (clk),
      .reset        (reset),
      .audio_i_l    (audio_i_l),
      .audio_i_r    (audio_i_r),
      .audio_valid  (audio_valid),
      .lpf_en       (lpf_en),
      .i2s_bclk     (i2s_bclk),
      .i2s_lrclk    (i2s_lrclk),
      .i2s_sdata    (i2s_sdata),
      .frame_strobe (frame_strobe)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference filter step: acc + x - floor(acc / 2^F), or bypass x * 2^F.
   function automatic longint mstep(input longint acc, input logic [23:0] x, input logic en);
      longint xs;
      xs = longint'(signed'(x));
      if (en) return acc + xs - (acc >>> LPF_F);
      else    return xs <<< LPF_F;
   endfunction

   function automatic logic [23:0] my(input longint acc);
      longint t;
      t = acc >>> LPF_F;
      return t[23:0];
   endfunction

   function automatic logic within8(input logic [23:0] a, input logic [23:0] b);
      int d;
      d = int'(signed'(a)) - int'(signed'(b));
      return (d >= -8) && (d <= 8);
   endfunction

   task automatic push_const(input logic [23:0] l, input logic [23:0] r);
      frame_t f;
      f.l = l;
      f.r = r;
      exp_q.push_back(f);
      pushed++;
   endtask

   task automatic push_model();
      push_const(my(m_acc_l), my(m_acc_r));
   endtask

   // Called at a negedge; the sample is taken by the following posedge.
   task automatic pulse(input logic [23:0] l, input logic [23:0] r);
      audio_i_l   = l;
      audio_i_r   = r;
      audio_valid = 1'b1;
      @(negedge clk);
      audio_valid = 1'b0;
      m_acc_l = mstep(m_acc_l, l, lpf_en);
      m_acc_r = mstep(m_acc_r, r, lpf_en);
   endtask

   task automatic wait_strobe();
      bit seen;
      seen = 1'b0;
      for (int i = 0; (i < 600) && !seen; i++) begin
         @(negedge clk);
         if (frame_strobe) seen = 1'b1;
      end
      if (!seen) chk("strobe_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (((exp_q.size() > 0) || mon_busy) && (n < 2000)) begin
         @(negedge clk);
         n++;
      end
      if ((exp_q.size() > 0) || mon_busy) chk("drain_timeout", 32'd0, 32'd1);
   endtask

   // Release reset and check the startup waveform edge by edge.
   task automatic startup();
      logic [7:0] vb, vs, vl, vd;
      int lr_rise, strobe2;
      lr_rise = -1;
      strobe2 = -1;
      reset   = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         vb[i-1] = i2s_bclk;
         vs[i-1] = frame_strobe;
         vl[i-1] = i2s_lrclk;
         vd[i-1] = i2s_sdata;
      end
      chk("start_bclk",   {24'd0, vb}, 32'h0000_0066);
      chk("start_strobe", {24'd0, vs}, 32'h0000_0008);
      chk("start_lrclk",  {24'd0, vl}, 32'h0000_0007);
      chk("start_sdata",  {24'd0, vd}, 32'h0000_0000);
      for (int i = 9; i <= 300; i++) begin
         @(negedge clk);
         if ((lr_rise < 0) && i2s_lrclk) lr_rise = i;
         if ((strobe2 < 0) && frame_strobe) strobe2 = i;
      end
      chk("lrclk_rise",   lr_rise, 32'd132);
      chk("frame_period", strobe2, 32'd260);
   endtask

   // Frame monitor: sample SDATA/LRCLK on BCLK rises after a frame strobe.
   initial begin
      frame_t      cur;
      logic [63:0] bits;
      logic [23:0] gl, gr;
      logic        pad;
      int          cnt;
      bit          prev_b;
      bit          lr_bad;
      cnt    = 0;
      prev_b = 1'b0;
      lr_bad = 1'b0;
      bits   = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            mon_busy = 1'b0;
            prev_b   = 1'b0;
         end else begin
            if (mon_busy && i2s_bclk && !prev_b) begin
               bits[cnt] = i2s_sdata;
               if (i2s_lrclk !== ((cnt >= 32) ? 1'b1 : 1'b0)) lr_bad = 1'b1;
               cnt++;
               if (cnt == 64) begin
                  for (int j = 0; j < 24; j++) begin
                     gl[23-j] = bits[1+j];
                     gr[23-j] = bits[33+j];
                  end
                  pad = bits[0] | (|bits[32:25]) | (|bits[63:57]);
                  chk("frame_l",     {8'd0, gl}, {8'd0, cur.l});
                  chk("frame_r",     {8'd0, gr}, {8'd0, cur.r});
                  chk("frame_pad",   {31'd0, pad}, 32'd0);
                  chk("frame_lrclk", {31'd0, lr_bad}, 32'd0);
                  last_l   = gl;
                  last_r   = gr;
                  compared++;
                  mon_busy = 1'b0;
               end
            end
            if (frame_strobe && !mon_busy && (exp_q.size() > 0)) begin
               cur      = exp_q.pop_front();
               mon_busy = 1'b1;
               cnt      = 0;
               lr_bad   = 1'b0;
               bits     = '0;
            end
            prev_b = i2s_bclk;
         end
      end
   end

   initial begin
      reset       = 1'b1;
      audio_i_l   = 24'd0;
      audio_i_r   = 24'd0;
      audio_valid = 1'b0;
      lpf_en      = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {28'd0, i2s_bclk, i2s_lrclk, i2s_sdata, frame_strobe}, 32'h4);
      startup();

      // Bypass serialization
      pulse(24'h123456, 24'hABCDEF);
      chk("bypass_y_l", {8'd0, dut.y_l_s}, 32'h0012_3456);
      @(negedge clk);
      push_const(24'h123456, 24'hABCDEF);
      drain();

      // Filter step response from a cleared accumulator
      pulse(24'h000000, 24'h000000);
      lpf_en = 1'b1;
      pulse(24'h100000, 24'hF00000);
      chk("step1_y_l", {8'd0, dut.y_l_s}, 32'h0002_0000);
      chk("step1_y_r", {8'd0, dut.y_r_s}, 32'h00FE_0000);
      @(negedge clk);
      push_const(24'h020000, 24'hFE0000);
      drain();
      pulse(24'h100000, 24'hF00000);
      chk("step2_y_l", {8'd0, dut.y_l_s}, 32'h0003_C000);
      chk("step2_y_r", {8'd0, dut.y_r_s}, 32'h00FC_4000);
      @(negedge clk);
      push_const(24'h03C000, 24'hFC4000);
      drain();
      repeat (198) pulse(24'h100000, 24'hF00000);
      @(negedge clk);
      push_model();
      drain();
      chk("converge_l", {31'd0, within8(last_l, 24'h100000)}, 32'd1);
      chk("converge_r", {31'd0, within8(last_r, 24'hF00000)}, 32'd1);

      // Full-scale inputs: track every step, never wrap
      lpf_en = 1'b0;
      pulse(24'h000000, 24'h000000);
      lpf_en = 1'b1;
      for (int i = 0; i < 300; i++) begin
         pulse(24'h800000, 24'h7FFFFF);
         if ((dut.y_l_s !== my(m_acc_l)) || (dut.y_r_s !== my(m_acc_r))) trk_err++;
         if (!dut.y_l_s[23] && (dut.y_l_s != 24'd0)) wrap_err++;
         if (dut.y_r_s[23]) wrap_err++;
      end
      chk("fs_track", trk_err, 32'd0);
      chk("fs_wrap",  wrap_err, 32'd0);
      @(negedge clk);
      push_model();
      drain();
      chk("fs_settle_l", {31'd0, within8(last_l, 24'h800000)}, 32'd1);
      chk("fs_settle_r", {31'd0, within8(last_r, 24'h7FFFFF)}, 32'd1);

      // Sample arriving exactly on the frame-latch edge
      lpf_en = 1'b0;
      wait_strobe();
      @(negedge clk);
      push_model();
      repeat (254) @(negedge clk);
      pulse(24'h0F0F0F, 24'h717171);
      chk("coincide_strobe", {31'd0, frame_strobe}, 32'd1);
      push_model();
      drain();

      // Reset in the middle of slot 40
      wait_strobe();
      repeat (161) @(negedge clk);
      chk("pre_reset_sdata", {31'd0, i2s_sdata}, 32'd1);
      reset   = 1'b1;
      m_acc_l = 0;
      m_acc_r = 0;
      @(negedge clk);
      chk("midreset_outputs", {29'd0, i2s_bclk, i2s_lrclk, i2s_sdata}, 32'h2);
      repeat (2) @(negedge clk);
      startup();

      chk("frames_compared", compared, pushed);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
